step_map_writer: RTL

//  Owns the Bumpy step tile map and is its write side: loads a level layout row by row, then applies

---
 rtl/step_map_pkg.sv | 30 +++
 rtl/step_level_rom.sv | 51 +++++
 rtl/step_map_writer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/step_map_pkg.sv
// Shared types and defaults for the Bumpy step tile map.
// Tile encodings, map FSM states, default map geometry and the tile degrade rule.
package step_map_pkg;

  localparam int unsigned MAP_COLS_DEF   = 10;
  localparam int unsigned MAP_ROWS_DEF   = 8;
  localparam int unsigned NUM_LEVELS_DEF = 4;

  typedef enum logic [2:0] {
    STEP_NONE   = 3'd0,
    STEP_SOLID  = 3'd1,
    STEP_BREAK  = 3'd2,
    STEP_SPRING = 3'd3
  } step_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } map_state_t;

  // One hit on a tile: breakable steps vanish, springs flatten to solid, others hold.
  function automatic logic [2:0] degrade(input logic [2:0] t);
    case (t)
      STEP_BREAK:  return STEP_NONE;
      STEP_SPRING: return STEP_SOLID;
      default:     return t;
    endcase
  endfunction

endpackage

// File: rtl/step_level_rom.sv
// Level layout ROM: returns one full row of tile types for (level, row).
// Purely combinational; rows or levels beyond the configured geometry read as empty.
module step_level_rom
  import step_map_pkg::*;
#(
  parameter int unsigned MAP_COLS   = MAP_COLS_DEF,
  parameter int unsigned MAP_ROWS   = MAP_ROWS_DEF,
  parameter int unsigned NUM_LEVELS = NUM_LEVELS_DEF
) (
  input  logic [1:0]                i_level,
  input  logic [2:0]                i_row,
  output logic [MAP_COLS-1:0][2:0]  o_row
);

  logic w_valid;

  assign w_valid = (32'(i_level) < NUM_LEVELS) && (32'(i_row) < MAP_ROWS);

  // Layout tables, built per column from simple geometric rules.
  always_comb begin
    o_row = '0;
    if (w_valid) begin
      for (int unsigned c = 0; c < MAP_COLS; c++) begin
        case (i_level)
          // Level 0: a solid pillar in column 1 above a solid floor on row 5.
          2'd0: begin
            if ((i_row <= 3'd4 && c == 1) || i_row == 3'd5) o_row[c] = STEP_SOLID;
          end
          // Level 1: three breakables on row 2, spring/solid pair on row 4, solid floor.
          2'd1: begin
            if (i_row == 3'd2 && (c == 2 || c == 5 || c == 8)) o_row[c] = STEP_BREAK;
            if (i_row == 3'd4 && c == 0) o_row[c] = STEP_SPRING;
            if (i_row == 3'd4 && c == 9) o_row[c] = STEP_SOLID;
            if (i_row == 3'd7) o_row[c] = STEP_SOLID;
          end
          // Level 2: alternating breakable/solid on row 3, row of springs on row 6.
          2'd2: begin
            if (i_row == 3'd3) o_row[c] = c[0] ? STEP_SOLID : STEP_BREAK;
            if (i_row == 3'd6) o_row[c] = STEP_SPRING;
          end
          // Level 3: solid diagonal plus a single breakable in the top-right corner.
          default: begin
            if (c == 32'(i_row)) o_row[c] = STEP_SOLID;
            if (i_row == 3'd0 && c == 9) o_row[c] = STEP_BREAK;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/step_map_writer.sv
// Step tile map owner: loads a level layout row by row from step_level_rom,
// applies SET/DEGRADE tile updates over valid/ready, and serves a registered read port.
// Optional build macro STEP_MAP_TILE_COUNT_EN adds tiles_left/level_clear outputs.
module step_map_writer
  import step_map_pkg::*;
#(
  parameter int unsigned MAP_COLS   = MAP_COLS_DEF,
  parameter int unsigned MAP_ROWS   = MAP_ROWS_DEF,
  parameter int unsigned NUM_LEVELS = NUM_LEVELS_DEF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       level_start,
  input  logic [1:0] level_sel,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [3:0] upd_col,
  input  logic [2:0] upd_row,
  input  logic       upd_op,
  input  logic [2:0] upd_type,
  output logic       upd_err,
  input  logic [3:0] rd_col,
  input  logic [2:0] rd_row,
  output logic [2:0] rd_type,
  output logic       busy,
  output logic       load_done
`ifdef STEP_MAP_TILE_COUNT_EN
  ,
  output logic [6:0] tiles_left,
  output logic       level_clear
`endif
);

  map_state_t               r_state;
  logic [2:0]               r_row_cnt;
  logic [1:0]               r_level;
  logic                     r_load_done;
  logic                     r_err;
  logic [2:0]               r_rd;
  logic [2:0]               r_map [MAP_ROWS][MAP_COLS];

  logic [MAP_COLS-1:0][2:0] w_rom_row;
  logic                     w_last_row;
  logic                     w_load_we;
  logic                     w_accept;
  logic                     w_upd_in_range;
  logic                     w_upd_we;
  logic [2:0]               w_cur;
  logic [2:0]               w_new_val;
  logic [2:0]               w_rd_val;

  step_level_rom #(
    .MAP_COLS   (MAP_COLS),
    .MAP_ROWS   (MAP_ROWS),
    .NUM_LEVELS (NUM_LEVELS)
  ) u_rom (
    .i_level (r_level),
    .i_row   (r_row_cnt),
    .o_row   (w_rom_row)
  );

  // Ready is gated by resetN so no update can be accepted while reset is held.
  assign upd_ready      = resetN && (r_state == IDLE) && !level_start;
  assign w_accept       = upd_valid && upd_ready;
  assign w_upd_in_range = (32'(upd_col) < MAP_COLS) && (32'(upd_row) < MAP_ROWS);
  assign w_upd_we       = w_accept && w_upd_in_range;
  assign w_load_we      = (r_state == LOAD);
  assign w_last_row     = (32'(r_row_cnt) == MAP_ROWS - 1);
  assign w_new_val      = upd_op ? degrade(w_cur) : upd_type;

  assign busy      = (r_state == LOAD);
  assign load_done = r_load_done;
  assign upd_err   = r_err;
  assign rd_type   = r_rd;

  // Cell muxes for the update target and the read port; out-of-range coordinates yield 0.
  always_comb begin
    w_cur    = '0;
    w_rd_val = '0;
    for (int unsigned r = 0; r < MAP_ROWS; r++) begin
      for (int unsigned c = 0; c < MAP_COLS; c++) begin
        if (32'(upd_row) == r && 32'(upd_col) == c) w_cur    = r_map[r][c];
        if (32'(rd_row)  == r && 32'(rd_col)  == c) w_rd_val = r_map[r][c];
      end
    end
  end

  // Load sequencer: IDLE/LOAD with restart on level_start and a done pulse on completion.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_level     <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (level_start) begin
            r_state   <= LOAD;
            r_row_cnt <= '0;
            r_level   <= level_sel;
          end
        end
        LOAD: begin
          if (level_start) begin
            r_row_cnt <= '0;
            r_level   <= level_sel;
          end else if (w_last_row) begin
            r_state     <= IDLE;
            r_load_done <= 1'b1;
          end else begin
            r_row_cnt <= r_row_cnt + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Map storage: whole-row writes while loading, single-cell writes for accepted updates.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned r = 0; r < MAP_ROWS; r++) begin
        for (int unsigned c = 0; c < MAP_COLS; c++) begin
          r_map[r][c] <= '0;
        end
      end
    end else begin
      for (int unsigned r = 0; r < MAP_ROWS; r++) begin
        for (int unsigned c = 0; c < MAP_COLS; c++) begin
          if (w_load_we && 32'(r_row_cnt) == r) begin
            r_map[r][c] <= w_rom_row[c];
          end else if (w_upd_we && 32'(upd_row) == r && 32'(upd_col) == c) begin
            r_map[r][c] <= w_new_val;
          end
        end
      end
    end
  end

  // Registered read port and error pulse for accepted out-of-range updates.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_rd  <= w_rd_val;
      r_err <= w_accept && !w_upd_in_range;
    end
  end

`ifdef STEP_MAP_TILE_COUNT_EN
  logic [6:0] r_load_breaks;
  logic [6:0] r_tiles;
  logic       r_clear;
  logic [6:0] w_row_breaks;
  logic [6:0] w_load_total;

  assign tiles_left   = r_tiles;
  assign level_clear  = r_clear;
  assign w_load_total = r_load_breaks + w_row_breaks;

  // Breakable tiles in the ROM row currently being written.
  always_comb begin
    w_row_breaks = '0;
    for (int unsigned c = 0; c < MAP_COLS; c++) begin
      if (w_rom_row[c] == STEP_BREAK) w_row_breaks = w_row_breaks + 7'd1;
    end
  end

  // Breakable-tile counter: accumulated during load, published at its end, tracked per update.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_load_breaks <= '0;
      r_tiles       <= '0;
      r_clear       <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      if (r_state == LOAD) begin
        if (level_start) begin
          r_load_breaks <= '0;
        end else if (w_last_row) begin
          r_load_breaks <= '0;
          r_tiles       <= w_load_total;
          r_clear       <= (r_tiles != '0) && (w_load_total == '0);
        end else begin
          r_load_breaks <= w_load_total;
        end
      end else if (w_upd_we) begin
        if (w_cur == STEP_BREAK && w_new_val != STEP_BREAK) begin
          r_tiles <= r_tiles - 7'd1;
          r_clear <= (r_tiles == 7'd1);
        end else if (w_cur != STEP_BREAK && w_new_val == STEP_BREAK) begin
          r_tiles <= r_tiles + 7'd1;
        end
      end
    end
  end
`endif

endmodule
